// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
//
// 1149.1-style Test Access Port: 16-state TAP FSM on tms, instruction register,
// IDCODE / BYPASS data registers and the strobes that drive an external
// boundary-scan (bsr) chain. It also raises a debug reset request for the core.
//
// Ports
//   tck          JTAG clock; every register updates on the rising edge
//   trst         synchronous active-high reset (takes priority over tms)
//   tms          TAP mode select
//   tdi          serial data in
//   tdo          serial data out (decoded from registered state)
//   tdo_en       high while in Shift-IR or Shift-DR
//   bsr_tdi      head of the boundary-scan chain (straight from tdi)
//   bsr_tdo      tail of the boundary-scan chain
//   bsr_capture  bsr capture strobe (Capture-DR with bsr selected)
//   bsr_shift    bsr shift enable  (Shift-DR with bsr selected)
//   bsr_update   bsr update strobe (Update-DR with bsr selected)
//   bsr_mode     1 while EXTEST is the active instruction
//   dm_reset     core reset request (DMRESET active and FSM in Run-Test/Idle)
//   tap_state    current TAP state encoding
//   ir           active instruction
// -----------------------------------------------------------------------------
module jtag_tap_controller #(
  parameter int unsigned          IR_WIDTH      = 4,
  // bit 0 of the device ID must be 1
  parameter logic [31:0]          IDCODE_VAL    = 32'h1000_0CFB,
  parameter logic [IR_WIDTH-1:0]  INSTR_EXTEST  = IR_WIDTH'(4'h0),
  parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE  = IR_WIDTH'(4'h1),
  parameter logic [IR_WIDTH-1:0]  INSTR_SAMPLE  = IR_WIDTH'(4'h2),
  parameter logic [IR_WIDTH-1:0]  INSTR_DMRESET = IR_WIDTH'(4'h8)
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_tdi,
  input  logic                bsr_tdo,
  output logic                bsr_capture,
  output logic                bsr_shift,
  output logic                bsr_update,
  output logic                bsr_mode,
  output logic                dm_reset,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir
);

  typedef enum logic [3:0] {
    ST_TLR     = 4'hF,
    ST_RTI     = 4'hC,
    ST_SEL_DR  = 4'h7,
    ST_CAP_DR  = 4'h6,
    ST_SH_DR   = 4'h2,
    ST_EX1_DR  = 4'h1,
    ST_PAU_DR  = 4'h3,
    ST_EX2_DR  = 4'h0,
    ST_UPD_DR  = 4'h5,
    ST_SEL_IR  = 4'h4,
    ST_CAP_IR  = 4'hE,
    ST_SH_IR   = 4'hA,
    ST_EX1_IR  = 4'h9,
    ST_PAU_IR  = 4'hB,
    ST_EX2_IR  = 4'h8,
    ST_UPD_IR  = 4'hD
  } tap_state_e;

  tap_state_e          r_state;
  tap_state_e          w_next_state;

  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [31:0]         r_id_shift;
  logic                r_bypass;

  logic                w_sel_id;
  logic                w_sel_bsr;
  logic                w_sel_byp;

  // ---------------------------------------------------------------------------
  // TAP state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge tck) begin
    if (trst) begin
      r_state <= ST_TLR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // TAP next-state graph
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_TLR:    w_next_state = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    w_next_state = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: w_next_state = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: w_next_state = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  w_next_state = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: w_next_state = tms ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: w_next_state = tms ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: w_next_state = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: w_next_state = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: w_next_state = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: w_next_state = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  w_next_state = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: w_next_state = tms ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: w_next_state = tms ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: w_next_state = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: w_next_state = tms ? ST_SEL_DR : ST_RTI;
      default:   w_next_state = ST_TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-register select from the active instruction.
  // IDCODE wins over the bsr codes; everything unrecognised falls to bypass.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_id  = (r_ir == INSTR_IDCODE);
    w_sel_bsr = !w_sel_id &&
                ((r_ir == INSTR_EXTEST) || (r_ir == INSTR_SAMPLE));
    w_sel_byp = !w_sel_id && !w_sel_bsr;
  end

  // ---------------------------------------------------------------------------
  // Instruction and internal data registers. All actions are keyed on the
  // state being occupied at the edge, so UpdIR's new ir is visible one edge
  // after the FSM enters UpdIR, and TLR re-forces IDCODE every cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir       <= INSTR_IDCODE;
      r_ir_shift <= '0;
      r_id_shift <= '0;
      r_bypass   <= 1'b0;
    end else begin
      case (r_state)
        ST_TLR: begin
          r_ir <= INSTR_IDCODE;
        end
        ST_CAP_IR: begin
          r_ir_shift <= IR_WIDTH'(2'b01);
        end
        ST_SH_IR: begin
          r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        end
        ST_UPD_IR: begin
          r_ir <= r_ir_shift;
        end
        ST_CAP_DR: begin
          r_id_shift <= IDCODE_VAL;
          r_bypass   <= 1'b0;
        end
        ST_SH_DR: begin
          if (w_sel_id) begin
            r_id_shift <= {tdi, r_id_shift[31:1]};
          end
          if (w_sel_byp) begin
            r_bypass <= tdi;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (all from registered state, bsr_tdo passes through in ShDR)
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo = 1'b0;
    if (r_state == ST_SH_IR) begin
      tdo = r_ir_shift[0];
    end else if (r_state == ST_SH_DR) begin
      if (w_sel_id) begin
        tdo = r_id_shift[0];
      end else if (w_sel_bsr) begin
        tdo = bsr_tdo;
      end else begin
        tdo = r_bypass;
      end
    end
  end

  always_comb begin
    tdo_en      = (r_state == ST_SH_IR) || (r_state == ST_SH_DR);
    bsr_tdi     = tdi;
    bsr_capture = (r_state == ST_CAP_DR) && w_sel_bsr;
    bsr_shift   = (r_state == ST_SH_DR)  && w_sel_bsr;
    bsr_update  = (r_state == ST_UPD_DR) && w_sel_bsr;
    bsr_mode    = (r_ir == INSTR_EXTEST);
    dm_reset    = (r_ir == INSTR_DMRESET) && (r_state == ST_RTI);
    tap_state   = r_state;
    ir          = r_ir;
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
module tb_jtag_tap_controller;

  localparam logic [31:0] IDC       = 32'h1000_0CFB;
  localparam logic [3:0]  I_EXTEST  = 4'h0;
  localparam logic [3:0]  I_IDCODE  = 4'h1;
  localparam logic [3:0]  I_SAMPLE  = 4'h2;
  localparam logic [3:0]  I_DMRESET = 4'h8;
  localparam logic [3:0]  I_BYPASS  = 4'hF;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  logic       tck = 1'b0;
  logic       trst = 1'b1, tms = 1'b0, tdi = 1'b0, bsr_tdo = 1'b0;
  logic       tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset;
  logic [3:0] tap_state, ir;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  jtag_tap_controller #(
    .IR_WIDTH     (4),
    .IDCODE_VAL   (IDC),
    .INSTR_EXTEST (I_EXTEST),
    .INSTR_IDCODE (I_IDCODE),
    .INSTR_SAMPLE (I_SAMPLE),
    .INSTR_DMRESET(I_DMRESET)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo), .bsr_capture(bsr_capture),
    .bsr_shift(bsr_shift), .bsr_update(bsr_update), .bsr_mode(bsr_mode),
    .dm_reset(dm_reset), .tap_state(tap_state), .ir(ir)
  );

  // ---------------- reference model ----------------
  // TAP graph as two successor tables indexed by state code.
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_st, m_ir, m_irs;
  logic [31:0] m_ids;
  logic        m_byp;

  initial begin
    nxt0[S_TLR]   = S_RTI;   nxt1[S_TLR]   = S_TLR;
    nxt0[S_RTI]   = S_RTI;   nxt1[S_RTI]   = S_SELDR;
    nxt0[S_SELDR] = S_CAPDR; nxt1[S_SELDR] = S_SELIR;
    nxt0[S_CAPDR] = S_SHDR;  nxt1[S_CAPDR] = S_EX1DR;
    nxt0[S_SHDR]  = S_SHDR;  nxt1[S_SHDR]  = S_EX1DR;
    nxt0[S_EX1DR] = S_PAUDR; nxt1[S_EX1DR] = S_UPDDR;
    nxt0[S_PAUDR] = S_PAUDR; nxt1[S_PAUDR] = S_EX2DR;
    nxt0[S_EX2DR] = S_SHDR;  nxt1[S_EX2DR] = S_UPDDR;
    nxt0[S_UPDDR] = S_RTI;   nxt1[S_UPDDR] = S_SELDR;
    nxt0[S_SELIR] = S_CAPIR; nxt1[S_SELIR] = S_TLR;
    nxt0[S_CAPIR] = S_SHIR;  nxt1[S_CAPIR] = S_EX1IR;
    nxt0[S_SHIR]  = S_SHIR;  nxt1[S_SHIR]  = S_EX1IR;
    nxt0[S_EX1IR] = S_PAUIR; nxt1[S_EX1IR] = S_UPDIR;
    nxt0[S_PAUIR] = S_PAUIR; nxt1[S_PAUIR] = S_EX2IR;
    nxt0[S_EX2IR] = S_SHIR;  nxt1[S_EX2IR] = S_UPDIR;
    nxt0[S_UPDIR] = S_RTI;   nxt1[S_UPDIR] = S_SELDR;
  end

  // 0 = bypass, 1 = idcode, 2 = boundary scan
  function automatic int msel(input logic [3:0] irv);
    if (irv == I_IDCODE) return 1;
    if (irv == I_EXTEST || irv == I_SAMPLE) return 2;
    return 0;
  endfunction

  function automatic logic [15:0] model_vec();
    int   s;
    logic o;
    s = msel(m_ir);
    o = 1'b0;
    if (m_st == S_SHIR) o = m_irs[0];
    else if (m_st == S_SHDR) o = (s == 1) ? m_ids[0] : (s == 2) ? bsr_tdo : m_byp;
    return {o, (m_st == S_SHIR || m_st == S_SHDR), tdi,
            (m_st == S_CAPDR && s == 2), (m_st == S_SHDR && s == 2), (m_st == S_UPDDR && s == 2),
            (m_ir == I_EXTEST), (m_ir == I_DMRESET && m_st == S_RTI), m_st, m_ir};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset,
            tap_state, ir};
  endfunction

  // One tck cycle: drive inputs, advance the model on the rising edge, return
  // shortly after the falling edge with outputs settled.
  task automatic step(input logic ms, input logic di, input logic rst);
    int s;
    tms = ms; tdi = di; trst = rst; bsr_tdo = 1'($urandom);
    @(posedge tck);
    s = msel(m_ir);
    if (rst) begin
      m_st = S_TLR; m_ir = I_IDCODE; m_irs = '0; m_ids = '0; m_byp = 1'b0;
    end else begin
      if (m_st == S_TLR)   m_ir = I_IDCODE;
      if (m_st == S_CAPIR) m_irs = 4'd1;
      if (m_st == S_SHIR)  m_irs = (m_irs >> 1) | (4'(di) << 3);
      if (m_st == S_UPDIR) m_ir = m_irs;
      if (m_st == S_CAPDR) begin m_ids = IDC; m_byp = 1'b0; end
      if (m_st == S_SHDR && s == 1) m_ids = (m_ids >> 1) | (32'(di) << 31);
      if (m_st == S_SHDR && s == 0) m_byp = di;
      m_st = ms ? nxt1[m_st] : nxt0[m_st];
    end
    @(negedge tck);
    #1;
  endtask

  // From RTI: shift a 4-bit instruction LSB-first, stop in Update-IR.
  task automatic load_ir(input logic [3:0] val);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 4; k++) step(k == 3, val[k], 0);
    step(1, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1, 0, 1);  // tms=1 must lose to reset
    checks++;
    if (tap_state !== S_TLR) begin errors++; $display("FAIL reset_state got %h exp %h", tap_state, S_TLR); end
    checks++;
    if (ir !== I_IDCODE) begin errors++; $display("FAIL reset_ir got %h exp %h", ir, I_IDCODE); end
    checks++;
    if ({tdo, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000000",
                         {tdo, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset});
    end
    checks++;
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL reset_vec got %h exp %h", dut_vec(), model_vec()); end
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    int          strobes;
    strobes = 0;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (tap_state !== S_SHDR) begin errors++; $display("FAIL idcode_enter got %h exp %h", tap_state, S_SHDR); end
    for (int k = 0; k < 32; k++) begin
      got[k] = tdo;
      strobes += int'(bsr_capture) + int'(bsr_shift) + int'(bsr_update);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL idcode_vec got %h exp %h", dut_vec(), model_vec()); end
      step(k == 31, 1'($urandom), 0);
    end
    checks++;
    if (got !== IDC) begin errors++; $display("FAIL idcode_value got %h exp %h", got, IDC); end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL idcode_bsr_strobes got %0d exp 0", strobes); end
    step(1, 0, 0); step(0, 0, 0);
    checks++;
    if (tap_state !== S_RTI) begin errors++; $display("FAIL idcode_exit got %h exp %h", tap_state, S_RTI); end
  endtask

  task automatic test_ir_capture();
    logic [3:0] got;
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      got[k] = tdo;
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL irshift_vec got %h exp %h", dut_vec(), model_vec()); end
      step(k == 3, 1'b1, 0);
    end
    checks++;  // capture pattern ...0001 comes out LSB first
    if (got !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b exp 0001", got); end
    step(1, 0, 0);
    step(0, 0, 0);
    checks++;
    if (ir !== I_BYPASS) begin errors++; $display("FAIL ir_update got %h exp %h", ir, I_BYPASS); end
  endtask

  task automatic test_bypass();
    logic [3:0] pat, got;
    pat = 4'b1101;  // shifted as 1,0,1,1
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      got[k] = tdo;
      step(k == 3, pat[k], 0);
    end
    checks++;
    if (got !== {pat[2:0], 1'b0}) begin errors++; $display("FAIL bypass_delay got %b exp %b", got, {pat[2:0], 1'b0}); end
    step(1, 0, 0); step(0, 0, 0);
  endtask

  task automatic test_extest();
    int cap, sh, upd;
    logic t;
    cap = 0; sh = 0; upd = 0;
    load_ir(I_EXTEST);
    step(0, 0, 0);
    checks++;
    if (bsr_mode !== 1'b1) begin errors++; $display("FAIL extest_mode got %b exp 1", bsr_mode); end
    for (int k = 0; k < 166; k++) begin
      t = (k == 0) || (k == 163) || (k == 164);
      step(t, 1'($urandom), 0);
      cap += int'(bsr_capture); sh += int'(bsr_shift); upd += int'(bsr_update);
      if (tap_state == S_SHDR) begin
        checks++;
        if (tdo !== bsr_tdo) begin errors++; $display("FAIL extest_tdo got %b exp %b", tdo, bsr_tdo); end
      end
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL extest_vec got %h exp %h", dut_vec(), model_vec()); end
    end
    checks++;
    if ({cap, sh, upd} !== {32'd1, 32'd161, 32'd1}) begin
      errors++; $display("FAIL extest_strobes got %0d/%0d/%0d exp 1/161/1", cap, sh, upd);
    end
    checks++;
    if (tap_state !== S_RTI || bsr_mode !== 1'b1) begin
      errors++; $display("FAIL extest_end got %h/%b exp %h/1", tap_state, bsr_mode, S_RTI);
    end
  endtask

  task automatic test_abort();
    int upd, mupd;
    upd = 0; mupd = 0;
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1'($urandom), 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      upd += int'(bsr_update); mupd += int'(model_vec() >> 10) & 1;
    end
    checks++;
    if (tap_state !== S_TLR) begin errors++; $display("FAIL abort_tlr got %h exp %h", tap_state, S_TLR); end
    checks++;
    if (upd != mupd) begin errors++; $display("FAIL abort_update got %0d exp %0d", upd, mupd); end
    step(1, 0, 0);
    checks++;
    if (ir !== I_IDCODE || bsr_mode !== 1'b0) begin
      errors++; $display("FAIL abort_ir got %h/%b exp %h/0", ir, bsr_mode, I_IDCODE);
    end
    // trst in the middle of an EXTEST shift: no update strobe afterwards
    step(0, 0, 0);
    load_ir(I_EXTEST);
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(0, 0, 1);
    upd = int'(bsr_update);
    checks++;
    if (tap_state !== S_TLR || ir !== I_IDCODE) begin
      errors++; $display("FAIL trst_dr got %h/%h exp %h/%h", tap_state, ir, S_TLR, I_IDCODE);
    end
    for (int k = 0; k < 3; k++) begin step(1, 0, 0); upd += int'(bsr_update); end
    checks++;
    if (upd != 0) begin errors++; $display("FAIL trst_dr_update got %0d exp 0", upd); end
    // trst in the middle of Shift-IR with tms low
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 1);
    checks++;
    if (tap_state !== S_TLR || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL trst_ir got %h exp %h", dut_vec(), model_vec());
    end
    step(0, 0, 0);
  endtask

  task automatic test_dmreset();
    int cnt;
    logic [3:0] seq;
    cnt = 0; seq = 4'b1000;
    load_ir(I_DMRESET);
    checks++;
    if (dm_reset !== 1'b0) begin errors++; $display("FAIL dmreset_updir got %b exp 0", dm_reset); end
    for (int k = 0; k < 4; k++) begin
      step(seq[k], 0, 0);
      cnt += int'(dm_reset);
    end
    checks++;
    if (cnt != 3) begin errors++; $display("FAIL dmreset_cycles got %0d exp 3", cnt); end
    checks++;
    if (dm_reset !== 1'b0 || tap_state !== S_SELDR) begin
      errors++; $display("FAIL dmreset_leave got %b/%h exp 0/%h", dm_reset, tap_state, S_SELDR);
    end
  endtask

  task automatic test_random();
    step(0, 0, 1);
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 100) < 40, 1'($urandom), ($urandom % 80) == 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_vec cycle %0d got %h exp %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge tck);
    #1;
    test_reset();
    test_idcode();
    test_ir_capture();
    test_bypass();
    test_extest();
    test_abort();
    test_dmreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
